// File: rtl/wb_scheduler_pkg.sv
// Shared types and constants for the writeback scheduler and its arbiter.
package wb_scheduler_pkg;

  typedef logic [4:0]  creg_addr_t;
  typedef logic [63:0] u64;

  localparam int N_WB_REQ         = 3;
  localparam int AREG_WRITE_PORTS = 2;

  typedef struct packed {
    logic       valid;
    creg_addr_t wa;
    u64         wd;
  } wb_req_t;

  // Pointer width for an n-way round-robin; never collapses to zero bits.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_scheduler_rr_arbiter.sv
// Combinational N-way round-robin arbiter granting up to M requesters per cycle.
// Grants are handed out in scan order starting at i_ptr; the k-th grant is
// reported on port slot k together with the index of the requester it carries.
module wb_scheduler_rr_arbiter
  import wb_scheduler_pkg::*;
#(
  parameter int N  = 3,
  parameter int M  = 2,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_port_idx [M],
  output logic [M-1:0]  o_port_vld,
  output logic [PW-1:0] o_next_ptr
);

  int   w_cnt;
  int   w_idx;
  int   w_last;
  logic w_any;

  // Scan from the pointer upward, modulo N, and fill port slots in order.
  always_comb begin
    o_grant    = '0;
    o_port_vld = '0;
    for (int k = 0; k < M; k++) o_port_idx[k] = '0;
    w_cnt  = 0;
    w_idx  = 0;
    w_last = 0;
    w_any  = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(i_ptr) + i) % N;
      if (i_valid[w_idx] && (w_cnt < M)) begin
        o_grant[w_idx]    = 1'b1;
        o_port_idx[w_cnt] = PW'(w_idx);
        o_port_vld[w_cnt] = 1'b1;
        w_cnt             = w_cnt + 1;
        w_last            = w_idx;
        w_any             = 1'b1;
      end
    end
    o_next_ptr = w_any ? PW'((w_last + 1) % N) : i_ptr;
  end

endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler and register scoreboard.
// Tracks destination registers with outstanding writes, holds issue on any
// hazard against them, and arbitrates writeback sources onto the register
// file write ports through one registered stage.
module wb_scheduler
  import wb_scheduler_pkg::*;
#(
  parameter int N_REQ       = N_WB_REQ,
  parameter int WRITE_PORTS = AREG_WRITE_PORTS
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_issue_valid,
  input  creg_addr_t         i_issue_src1,
  input  creg_addr_t         i_issue_src2,
  input  creg_addr_t         i_issue_dst,
  output logic               o_issue_ready,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  creg_addr_t         i_req_wa [N_REQ],
  input  u64                 i_req_wd [N_REQ],
  output logic [N_REQ-1:0]   o_req_ready,
  output creg_addr_t         o_wa     [WRITE_PORTS],
  output logic               o_wvalid [WRITE_PORTS],
  output u64                 o_wd     [WRITE_PORTS],
  output logic [31:0]        o_pending
);

  localparam int PW = ptr_w(N_REQ);

  wb_req_t          w_req [N_REQ];
  logic [PW-1:0]    r_rr_ptr;
  logic [N_REQ-1:0] w_grant;
  logic [PW-1:0]    w_port_idx [WRITE_PORTS];
  logic [WRITE_PORTS-1:0] w_port_vld;
  logic [PW-1:0]    w_next_ptr;

  logic [31:0]      r_pending;
  logic [31:0]      w_set;
  logic [31:0]      w_clr;
  logic [31:0]      w_pending_nxt;

  creg_addr_t       r_wa     [WRITE_PORTS];
  logic             r_wvalid [WRITE_PORTS];
  u64               r_wd     [WRITE_PORTS];

  // Bundle the flat request inputs into one record per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_req[i].valid = i_req_valid[i];
      w_req[i].wa    = i_req_wa[i];
      w_req[i].wd    = i_req_wd[i];
    end
  end

  wb_scheduler_rr_arbiter #(
    .N  (N_REQ),
    .M  (WRITE_PORTS),
    .PW (PW)
  ) u_arb (
    .i_valid    (i_req_valid),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_port_idx (w_port_idx),
    .o_port_vld (w_port_vld),
    .o_next_ptr (w_next_ptr)
  );

  assign o_req_ready = w_grant;

  // Hazard check sees registered pending only; bit 0 is never set, so x0 is always free.
  assign o_issue_ready = !r_pending[i_issue_src1] && !r_pending[i_issue_src2] &&
                         !r_pending[i_issue_dst];

  // Next scoreboard: clear what the register file writes this edge, then set the new
  // destination so a set always wins an overlap.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_issue_valid && o_issue_ready && (i_issue_dst != '0))
      w_set[i_issue_dst] = 1'b1;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (r_wvalid[p] && (r_wa[p] != '0))
        w_clr[r_wa[p]] = 1'b1;
    end
    w_pending_nxt = ((r_pending & ~w_clr) | w_set) & ~32'h1;
  end

  // Scoreboard and round-robin pointer registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pending <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_rr_ptr  <= w_next_ptr;
    end
  end

  // Output stage: each granted request lands on its port; x0 writes are granted but not enabled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        r_wa[p]     <= '0;
        r_wvalid[p] <= 1'b0;
        r_wd[p]     <= '0;
      end
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (w_port_vld[p]) begin
          r_wa[p]     <= w_req[w_port_idx[p]].wa;
          r_wvalid[p] <= (w_req[w_port_idx[p]].wa != '0);
          r_wd[p]     <= w_req[w_port_idx[p]].wd;
        end else begin
          r_wa[p]     <= '0;
          r_wvalid[p] <= 1'b0;
          r_wd[p]     <= '0;
        end
      end
    end
  end

  assign o_wa      = r_wa;
  assign o_wvalid  = r_wvalid;
  assign o_wd      = r_wd;
  assign o_pending = r_pending;

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench: two-port instance for scoreboard/multi-port behaviour,
// single-port instance for the round-robin rotation.
module tb_wb_scheduler;
  import wb_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // two-port instance
  logic         d2_iv = 1'b0;
  creg_addr_t   d2_s1 = '0, d2_s2 = '0, d2_dst = '0;
  logic         d2_ir;
  logic [2:0]   d2_rv = '0;
  creg_addr_t   d2_rwa [3];
  u64           d2_rwd [3];
  logic [2:0]   d2_rr;
  creg_addr_t   d2_wa [2];
  logic         d2_wv [2];
  u64           d2_wd [2];
  logic [31:0]  d2_pend;

  // one-port instance
  logic         d1_iv = 1'b0;
  creg_addr_t   d1_s1 = '0, d1_s2 = '0, d1_dst = '0;
  logic         d1_ir;
  logic [2:0]   d1_rv = '0;
  creg_addr_t   d1_rwa [3];
  u64           d1_rwd [3];
  logic [2:0]   d1_rr;
  creg_addr_t   d1_wa [1];
  logic         d1_wv [1];
  u64           d1_wd [1];
  logic [31:0]  d1_pend;

  wb_scheduler #(.N_REQ(3), .WRITE_PORTS(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst),
    .i_issue_valid(d2_iv), .i_issue_src1(d2_s1), .i_issue_src2(d2_s2), .i_issue_dst(d2_dst),
    .o_issue_ready(d2_ir),
    .i_req_valid(d2_rv), .i_req_wa(d2_rwa), .i_req_wd(d2_rwd), .o_req_ready(d2_rr),
    .o_wa(d2_wa), .o_wvalid(d2_wv), .o_wd(d2_wd), .o_pending(d2_pend)
  );

  wb_scheduler #(.N_REQ(3), .WRITE_PORTS(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_issue_valid(d1_iv), .i_issue_src1(d1_s1), .i_issue_src2(d1_s2), .i_issue_dst(d1_dst),
    .o_issue_ready(d1_ir),
    .i_req_valid(d1_rv), .i_req_wa(d1_rwa), .i_req_wd(d1_rwd), .o_req_ready(d1_rr),
    .o_wa(d1_wa), .o_wvalid(d1_wv), .o_wd(d1_wd), .o_pending(d1_pend)
  );

  typedef struct {
    int         port;
    creg_addr_t wa;
    u64         wd;
  } wb_exp_t;

  wb_exp_t q2[$];
  wb_exp_t q1[$];

  // Two granted writes to the same non-zero register in one cycle must never appear.
  always @(negedge clk) begin
    if (!rst && d2_wv[0] && d2_wv[1] && (d2_wa[0] == d2_wa[1]) && (d2_wa[0] != '0)) begin
      errors++;
      $display("FAIL dup_dest both ports wa=%0d", d2_wa[0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input int port, input creg_addr_t wa, input u64 wd);
    wb_exp_t e;
    e.port = port; e.wa = wa; e.wd = wd;
    q2.push_back(e);
  endtask

  // Pop one expected write per active port; anything left over never appeared.
  task automatic sample_wb2(input string tag);
    wb_exp_t e;
    for (int p = 0; p < 2; p++) begin
      if (d2_wv[p]) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected write port=%0d wa=%0d", tag, p, d2_wa[p]);
        end else begin
          e = q2.pop_front();
          if (e.port !== p || d2_wa[p] !== e.wa || d2_wd[p] !== e.wd) begin
            errors++;
            $display("FAIL %s got port=%0d wa=%0d wd=%h expected port=%0d wa=%0d wd=%h",
                     tag, p, d2_wa[p], d2_wd[p], e.port, e.wa, e.wd);
          end
        end
      end
    end
    while (q2.size() > 0) begin
      e = q2.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing write port=%0d wa=%0d wd=%h", tag, e.port, e.wa, e.wd);
    end
  endtask

  task automatic chk_ready(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s issue_ready got=%0b expected=%0b", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    step();
    rst = 1'b0;
    step();
    d2_s1 = 5'd3; d2_s2 = 5'd4; d2_dst = 5'd5;
    #1;
    checks++;
    if (d2_pend !== 32'h0) begin
      errors++; $display("FAIL reset_pending got=%h expected=0", d2_pend);
    end
    chk_ready("reset_ready", d2_ir, 1'b1);
    // Make something active: issue dst=3 and write wa=9 from requester 0.
    d2_iv = 1'b1; d2_s1 = '0; d2_s2 = '0; d2_dst = 5'd3;
    d2_rv = 3'b001; d2_rwa[0] = 5'd9; d2_rwd[0] = 64'h1234;
    push2(0, 5'd9, 64'h1234);
    step();
    d2_iv = 1'b0; d2_rv = '0; d2_dst = '0;
    checks++;
    if (d2_pend !== 32'h8) begin
      errors++; $display("FAIL active_pending got=%h expected=8", d2_pend);
    end
    sample_wb2("active_wb");
    // Reset mid-cycle: outputs drop before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (d2_wv[0] !== 1'b0 || d2_wa[0] !== '0 || d2_wd[0] !== '0 || d2_pend !== 32'h0) begin
      errors++;
      $display("FAIL async_reset wv=%0b wa=%0d wd=%h pend=%h expected all 0",
               d2_wv[0], d2_wa[0], d2_wd[0], d2_pend);
    end
    d2_s1 = 5'd3; d2_s2 = 5'd4; d2_dst = 5'd5;
    #1;
    chk_ready("async_reset_ready", d2_ir, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    d2_s1 = '0; d2_s2 = '0; d2_dst = '0;
    step();
  endtask

  task automatic test_raw();
    d2_iv = 1'b1; d2_dst = 5'd5;
    #1;
    chk_ready("raw_issue_dst", d2_ir, 1'b1);
    step();
    d2_dst = '0; d2_s1 = 5'd5;
    d2_rv = 3'b010; d2_rwa[1] = 5'd5; d2_rwd[1] = 64'hDEAD;
    #1;
    chk_ready("raw_hold", d2_ir, 1'b0);
    checks++;
    if (d2_pend !== 32'h20 || d2_rr !== 3'b010) begin
      errors++; $display("FAIL raw_state pend=%h rr=%b expected pend=20 rr=010", d2_pend, d2_rr);
    end
    push2(0, 5'd5, 64'hDEAD);
    step();
    d2_rv = '0;
    sample_wb2("raw_wb");
    chk_ready("raw_still_held", d2_ir, 1'b0);
    step();
    chk_ready("raw_release", d2_ir, 1'b1);
    checks++;
    if (d2_pend !== 32'h0) begin
      errors++; $display("FAIL raw_clear pend=%h expected=0", d2_pend);
    end
    d2_iv = 1'b0; d2_s1 = '0;
  endtask

  task automatic test_waw();
    d2_iv = 1'b1; d2_dst = 5'd7;
    step();
    #1;
    chk_ready("waw_hold", d2_ir, 1'b0);
    d2_dst = '0;
    #1;
    chk_ready("waw_x0_ready", d2_ir, 1'b1);
    step();
    d2_iv = 1'b0;
    checks++;
    if (d2_pend !== 32'h80) begin
      errors++; $display("FAIL waw_x0_noset pend=%h expected=80", d2_pend);
    end
    d2_rv = 3'b001; d2_rwa[0] = 5'd7; d2_rwd[0] = 64'h77;
    push2(0, 5'd7, 64'h77);
    step();
    d2_rv = '0;
    sample_wb2("waw_wb");
    step();
    checks++;
    if (d2_pend !== 32'h0) begin
      errors++; $display("FAIL waw_clear pend=%h expected=0", d2_pend);
    end
  endtask

  // Pointer is 1 on entry (last grant went to requester 0).
  task automatic test_multi_port();
    d2_rv = 3'b101;
    d2_rwa[0] = 5'd20; d2_rwd[0] = 64'hA0;
    d2_rwa[2] = 5'd22; d2_rwd[2] = 64'hA2;
    #1;
    checks++;
    if (d2_rr !== 3'b101) begin
      errors++; $display("FAIL mp_ready got=%b expected=101", d2_rr);
    end
    push2(0, 5'd22, 64'hA2);
    push2(1, 5'd20, 64'hA0);
    step();
    sample_wb2("mp_wb");
    // Pointer should be 1 again: requester 1 first, then 0.
    d2_rv = 3'b011;
    d2_rwa[1] = 5'd21; d2_rwd[1] = 64'hA1;
    push2(0, 5'd21, 64'hA1);
    push2(1, 5'd20, 64'hA0);
    step();
    sample_wb2("mp_ptr_wb");
    // Three valid, two ports, pointer 1: grant 1 and 2, then 0 and 1.
    d2_rv = 3'b111;
    #1;
    checks++;
    if (d2_rr !== 3'b110) begin
      errors++; $display("FAIL bp_ready1 got=%b expected=110", d2_rr);
    end
    push2(0, 5'd21, 64'hA1);
    push2(1, 5'd22, 64'hA2);
    step();
    sample_wb2("bp_wb1");
    #1;
    checks++;
    if (d2_rr !== 3'b011) begin
      errors++; $display("FAIL bp_ready2 got=%b expected=011", d2_rr);
    end
    push2(0, 5'd20, 64'hA0);
    push2(1, 5'd21, 64'hA1);
    step();
    d2_rv = '0;
    sample_wb2("bp_wb2");
  endtask

  task automatic test_x0_write();
    d2_iv = 1'b1; d2_dst = 5'd8;
    d2_rv = 3'b001; d2_rwa[0] = '0; d2_rwd[0] = 64'h55;
    #1;
    checks++;
    if (d2_rr !== 3'b001) begin
      errors++; $display("FAIL x0_ready got=%b expected=001", d2_rr);
    end
    step();
    d2_iv = 1'b0; d2_dst = '0; d2_rv = '0;
    checks++;
    if (d2_wv[0] !== 1'b0 || d2_wv[1] !== 1'b0) begin
      errors++; $display("FAIL x0_wvalid got=%0b%0b expected=00", d2_wv[0], d2_wv[1]);
    end
    sample_wb2("x0_wb");
    step();
    checks++;
    if (d2_pend !== 32'h100) begin
      errors++; $display("FAIL x0_pending got=%h expected=100", d2_pend);
    end
  endtask

  task automatic test_round_robin();
    int mptr = 0;
    int pulses [3] = '{0, 0, 0};
    wb_exp_t e;
    for (int i = 0; i < 3; i++) begin
      d1_rwa[i] = creg_addr_t'(10 + i);
      d1_rwd[i] = 64'hB0 + 64'(i);
    end
    d1_rv = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (d1_rr !== (3'b001 << mptr)) begin
        errors++; $display("FAIL rr_grant cycle=%0d got=%b expected=%b", c, d1_rr, 3'b001 << mptr);
      end
      for (int i = 0; i < 3; i++) if (d1_rr[i]) pulses[i]++;
      e.port = 0; e.wa = creg_addr_t'(10 + mptr); e.wd = 64'hB0 + 64'(mptr);
      q1.push_back(e);
      mptr = (mptr + 1) % 3;
      step();
      e = q1.pop_front();
      checks++;
      if (d1_wv[0] !== 1'b1 || d1_wa[0] !== e.wa || d1_wd[0] !== e.wd) begin
        errors++;
        $display("FAIL rr_wb cycle=%0d got wv=%0b wa=%0d wd=%h expected wa=%0d wd=%h",
                 c, d1_wv[0], d1_wa[0], d1_wd[0], e.wa, e.wd);
      end
    end
    d1_rv = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pulses[i] != 2) begin
        errors++; $display("FAIL rr_pulses req=%0d got=%0d expected=2", i, pulses[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      d2_rwa[i] = '0; d2_rwd[i] = '0;
      d1_rwa[i] = '0; d1_rwd[i] = '0;
    end
    test_reset();
    test_raw();
    test_waw();
    test_multi_port();
    test_x0_write();
    test_round_robin();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_scheduler.md
# wb_scheduler

Writeback scheduler and register scoreboard for the pipelined core's architectural register file. It tracks destination registers with outstanding writes and holds issue on register hazards. It arbitrates N_REQ writeback sources (in-order pipe, mul/div unit, load unit) onto the register file's WRITE_PORTS write ports through one registered stage. It sits between the execute/memory units and the register file; its wa/wvalid/wd outputs drive the register file's write ports directly.

## Interface
- N_REQ, 3, number of writeback requesters
- WRITE_PORTS, AREG_WRITE_PORTS, register-file write ports driven per cycle
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode wants to issue an instruction
- issue_src1, issue_src2  in  creg_addr_t  source registers
- issue_dst  in  creg_addr_t  destination register; 0 means no write
- issue_ready  out  1  issue accepted this cycle when high with issue_valid
- req_valid  in  [N_REQ-1:0]  writeback request
- req_wa  in  creg_addr_t[N_REQ]  writeback destination
- req_wd  in  u64[N_REQ]  writeback data
- req_ready  out  [N_REQ-1:0]  request granted this cycle
- wa  out  creg_addr_t[WRITE_PORTS]  to register-file write address
- wvalid  out  u1[WRITE_PORTS]  to register-file write enable
- wd  out  u64[WRITE_PORTS]  to register-file write data
- pending  out  [31:0]  scoreboard bits, for debug and perf counters

## Operation
- **Scoreboard.** pending[31:0] is a register; bit 0 is constant 0.
- **Issue hazard check.**
  - issue_ready = !pending[issue_src1] && !pending[issue_src2] && !pending[issue_dst].
  - The check uses registered pending only; there is no same-cycle forwarding.
  - issue_ready is purely combinational and does not depend on issue_valid.
- **Set.** Accepted issue (issue_valid && issue_ready) with issue_dst != 0 sets pending[issue_dst] at the next edge.
- **Clear.** A port with wvalid[p]=1 and wa[p]!=0 clears pending[wa[p]] at the same edge the register file writes it.
- **Set/clear overlap.** Set and clear of the same bit in one cycle cannot occur, because set requires the bit clear and clear requires it set. If it does occur, set wins.
- **Arbitration.** This is round-robin over valid requesters with pointer rr_ptr (width $clog2(N_REQ)).
  - Scan from rr_ptr upward, modulo N_REQ, and grant the first min(WRITE_PORTS, #valid) valid requesters.
  - The k-th grant in scan order maps to port k.
  - req_ready is combinational from req_valid and rr_ptr. A requester must hold req_valid/req_wa/req_wd stable until granted.
- **Pointer update.** If any grant occurred, rr_ptr advances to (last granted index + 1) mod N_REQ. Otherwise it holds.
- **Output stage.**
  - Granted requests register into wa/wvalid/wd at the edge.
  - Ungranted ports register wvalid=0, wa=0, wd=0.
- **Requests with req_wa = 0.** They are granted and consume a port. They produce wvalid=0 and cause no pending change.
- **Duplicate destinations.** Two granted requests with equal non-zero wa in one cycle are illegal. The scoreboard prevents this; the bench asserts it never happens.

## Timing
- **Reset (async).** pending=0, rr_ptr=0, wa/wvalid/wd=0. issue_ready then reflects the all-clear scoreboard, i.e. 1.
- **Writeback latency.** Grant in cycle t, then wvalid at the register file in t+1, then the register is written at the end of t+1. pending clears at the same edge. A dependent issue is accepted in t+2 and reads the new value.
- **Issue-to-busy latency.** Issue accepted in cycle t makes pending visible in t+1.
- **Backpressure.** With more than WRITE_PORTS valid requesters, each requester waits at most ceil(N_REQ/WRITE_PORTS)-1 cycles of contention.
- **Reset mid-operation.** In-flight grants are discarded, outputs drop to 0 immediately, and all pending bits clear.

## Structure
- Shared package (pipes):
  - N_WB_REQ constant
  - wb_req_t struct {valid, wa, wd}
  - the creg_addr_t and u64 types already there
- One sub-module is natural: rr_arbiter (N, M grants, pointer in, grant vector and next pointer out, combinational). It can be reused for other shared resources.
- Scoreboard and output stage stay in wb_scheduler.

## Test plan
- **Reset.** Reset during active writes: outputs go 0 asynchronously, pending=0, and issue_ready=1 for src1=3, src2=4, dst=5.
- **RAW.** Issue dst=5, then issue src1=5: issue_ready=0. Requester 1 writes wa=5, wd=0xDEAD. wvalid/wa=5/wd=0xDEAD appear next cycle, and issue_ready=1 the cycle after.
- **WAW.** dst=7 is pending and issue dst=7 is held. issue_dst=0 with srcs=0 is always ready and never sets pending.
- **Round-robin.** WRITE_PORTS=1, all 3 requesters valid continuously: grants go 0,1,2,0,… with rr_ptr cycling, and each req_ready pulses one cycle in three.
- **Multi-port.** WRITE_PORTS=2, requesters 0 and 2 valid, rr_ptr=1: requester 2 maps to port 0 and requester 0 to port 1, and rr_ptr becomes 1.
- **x0 write.** A request with wa=0 is granted, req_ready=1, and the port shows wvalid=0. pending is unchanged.
